// File: rtl/point_mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : point_mult_sequencer_if
// Description : Handshake bundle between the point-multiplication sequencer
//               and its point-doubling / point-addition responders.
// Revision    : 1.0 - initial release
// ============================================================================
interface point_mult_sequencer_if #(
    parameter int WIDTH = 192
);
    // Doubler channel
    logic             o_dbl_start;
    logic [WIDTH-1:0] o_dbl_x;
    logic [WIDTH-1:0] o_dbl_y;
    logic             i_dbl_finish;
    logic [WIDTH-1:0] i_dbl_x;
    logic [WIDTH-1:0] i_dbl_y;

    // Adder channel
    logic             o_add_start;
    logic [WIDTH-1:0] o_add_x1;
    logic [WIDTH-1:0] o_add_y1;
    logic [WIDTH-1:0] o_add_x2;
    logic [WIDTH-1:0] o_add_y2;
    logic             i_add_finish;
    logic [WIDTH-1:0] i_add_x;
    logic [WIDTH-1:0] i_add_y;

    // Sequencer side: issues operations, consumes results
    modport master (
        output o_dbl_start, o_dbl_x, o_dbl_y,
        input  i_dbl_finish, i_dbl_x, i_dbl_y,
        output o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2,
        input  i_add_finish, i_add_x, i_add_y
    );

    // Responder side: consumes operations, returns results
    modport slave (
        input  o_dbl_start, o_dbl_x, o_dbl_y,
        output i_dbl_finish, i_dbl_x, i_dbl_y,
        input  o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2,
        output i_add_finish, i_add_x, i_add_y
    );
endinterface
`default_nettype wire

// File: rtl/point_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : point_mult_sequencer
// Description : Left-to-right double-and-add controller computing k*P by
//               delegating point doubling and point addition to external
//               responders over a start/finish handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module point_mult_sequencer #(
    parameter int               WIDTH = 192,
    parameter logic [WIDTH-1:0] INF   = {WIDTH{1'b1}}
) (
    input  wire                    i_clk,
    input  wire                    i_rst,
    input  wire                    i_start,
    input  wire  [WIDTH-1:0]       i_k,
    input  wire  [WIDTH-1:0]       i_x,
    input  wire  [WIDTH-1:0]       i_y,
    output logic                   o_busy,
    output logic                   o_finished,
    output logic [WIDTH-1:0]       o_result_x,
    output logic [WIDTH-1:0]       o_result_y,
    point_mult_sequencer_if.master resp_if
);

    localparam int                 c_IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_STEP     = 3'd1;
    localparam logic [2:0] c_DBL_WAIT = 3'd2;
    localparam logic [2:0] c_ADD_CHK  = 3'd3;
    localparam logic [2:0] c_ADD_WAIT = 3'd4;
    localparam logic [2:0] c_ADV      = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [WIDTH-1:0]   r_k;
    logic [WIDTH-1:0]   r_px;
    logic [WIDTH-1:0]   r_py;
    logic [WIDTH-1:0]   r_rx;
    logic [WIDTH-1:0]   r_ry;
    logic [WIDTH-1:0]   r_res_x;
    logic [WIDTH-1:0]   r_res_y;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_dbl_start;
    logic               r_add_start;
    logic               w_r_inf;
    logic               w_k_bit;

    // The accumulator is at infinity whenever its x equals the INF marker
    assign w_r_inf = (r_rx == INF);
    assign w_k_bit = r_k[r_idx];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; finishes only matter in their own wait state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:     if (i_start) w_next_state = c_STEP;
            c_STEP:     w_next_state = w_r_inf ? c_ADD_CHK : c_DBL_WAIT;
            c_DBL_WAIT: if (resp_if.i_dbl_finish) w_next_state = c_ADD_CHK;
            c_ADD_CHK: begin
                if (!w_k_bit || w_r_inf) begin
                    w_next_state = c_ADV;
                end else begin
                    w_next_state = c_ADD_WAIT;
                end
            end
            c_ADD_WAIT: if (resp_if.i_add_finish) w_next_state = c_ADV;
            c_ADV:      w_next_state = (r_idx == '0) ? c_DONE : c_STEP;
            c_DONE:     w_next_state = c_IDLE;
            default:    w_next_state = c_IDLE;
        endcase
    end

    // Operand latches, accumulator, bit index, result hold and start pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k         <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_idx       <= '0;
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_dbl_start <= 1'b0;
            r_add_start <= 1'b0;
        end else begin
            // Pulses rise with entry into the wait state and last one cycle
            r_dbl_start <= (r_state == c_STEP)    && (w_next_state == c_DBL_WAIT);
            r_add_start <= (r_state == c_ADD_CHK) && (w_next_state == c_ADD_WAIT);
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_k   <= i_k;
                        r_px  <= i_x;
                        r_py  <= i_y;
                        r_rx  <= INF;
                        r_ry  <= '0;
                        r_idx <= c_IDX_TOP;
                    end
                end
                c_DBL_WAIT: begin
                    if (resp_if.i_dbl_finish) begin
                        r_rx <= resp_if.i_dbl_x;
                        r_ry <= resp_if.i_dbl_y;
                    end
                end
                c_ADD_CHK: begin
                    // Adding P to infinity needs no adder: just load P
                    if (w_k_bit && w_r_inf) begin
                        r_rx <= r_px;
                        r_ry <= r_py;
                    end
                end
                c_ADD_WAIT: begin
                    if (resp_if.i_add_finish) begin
                        r_rx <= resp_if.i_add_x;
                        r_ry <= resp_if.i_add_y;
                    end
                end
                c_ADV: begin
                    // R is final here, so the result is visible during DONE
                    if (r_idx == '0) begin
                        r_res_x <= r_rx;
                        r_res_y <= r_ry;
                    end else begin
                        r_idx <= r_idx - c_IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; everything is held at zero while reset is asserted
    always_comb begin
        o_busy               = 1'b0;
        o_finished           = 1'b0;
        o_result_x           = '0;
        o_result_y           = '0;
        resp_if.o_dbl_start  = 1'b0;
        resp_if.o_dbl_x      = '0;
        resp_if.o_dbl_y      = '0;
        resp_if.o_add_start  = 1'b0;
        resp_if.o_add_x1     = '0;
        resp_if.o_add_y1     = '0;
        resp_if.o_add_x2     = '0;
        resp_if.o_add_y2     = '0;
        if (!i_rst) begin
            o_busy               = (r_state != c_IDLE);
            o_finished           = (r_state == c_DONE);
            o_result_x           = r_res_x;
            o_result_y           = r_res_y;
            resp_if.o_dbl_start  = r_dbl_start;
            resp_if.o_dbl_x      = r_rx;
            resp_if.o_dbl_y      = r_ry;
            resp_if.o_add_start  = r_add_start;
            resp_if.o_add_x1     = r_rx;
            resp_if.o_add_y1     = r_ry;
            resp_if.o_add_x2     = r_px;
            resp_if.o_add_y2     = r_py;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_point_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_point_mult_sequencer
// Description : Self-checking bench for point_mult_sequencer. Responders treat
//               points as integer multiples of P (doubling = 2*R, adding =
//               R+P), so k*P is simply (k*x, k*y) modulo 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_point_mult_sequencer;

    localparam int         W     = 192;
    localparam logic [W-1:0] INF_V = {W{1'b1}};
    localparam byte        EV_D  = 8'h44;
    localparam byte        EV_A  = 8'h41;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] k_in;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic         busy;
    logic         finished;
    logic [W-1:0] res_x;
    logic [W-1:0] res_y;

    point_mult_sequencer_if #(.WIDTH(W)) rif ();

    point_mult_sequencer #(.WIDTH(W), .INF(INF_V)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_k        (k_in),
        .i_x        (x_in),
        .i_y        (y_in),
        .o_busy     (busy),
        .o_finished (finished),
        .o_result_x (res_x),
        .o_result_y (res_y),
        .resp_if    (rif)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  dbl_lat  = 1;
    int  add_lat  = 1;
    bit  resp_en  = 1'b1;
    bit  stab_chk = 1'b1;
    int  stab_err = 0;
    int  both_err = 0;
    int  wide_err = 0;
    int  n_dbl    = 0;
    int  n_add    = 0;
    byte          ev_q[$];
    logic [W-1:0] ax1_q[$];
    logic [W-1:0] ay1_q[$];
    logic [W-1:0] ax2_q[$];
    logic [W-1:0] ay2_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
        $fatal(1, "watchdog expired");
    end

    // Start-pulse monitor: counts, ordering, overlap and pulse width
    initial begin : start_monitor
        bit prev_dbl;
        bit prev_add;
        prev_dbl = 1'b0;
        prev_add = 1'b0;
        forever begin
            @(negedge clk);
            if (rif.o_dbl_start && rif.o_add_start) both_err++;
            if (rif.o_dbl_start && prev_dbl) wide_err++;
            if (rif.o_add_start && prev_add) wide_err++;
            prev_dbl = rif.o_dbl_start;
            prev_add = rif.o_add_start;
            if (rif.o_dbl_start) begin
                n_dbl++;
                ev_q.push_back(EV_D);
            end
            if (rif.o_add_start) begin
                n_add++;
                ev_q.push_back(EV_A);
                ax1_q.push_back(rif.o_add_x1);
                ay1_q.push_back(rif.o_add_y1);
                ax2_q.push_back(rif.o_add_x2);
                ay2_q.push_back(rif.o_add_y2);
            end
        end
    end

    // Doubler responder: returns 2*R after dbl_lat cycles, watching operands
    initial begin : dbl_responder
        logic [W-1:0] cx;
        logic [W-1:0] cy;
        forever begin
            @(negedge clk);
            if (rif.o_dbl_start && resp_en) begin
                cx = rif.o_dbl_x;
                cy = rif.o_dbl_y;
                for (int i = 0; i < dbl_lat; i++) begin
                    @(negedge clk);
                    if (stab_chk && (rif.o_dbl_x !== cx || rif.o_dbl_y !== cy)) stab_err++;
                end
                rif.i_dbl_x      = cx + cx;
                rif.i_dbl_y      = cy + cy;
                rif.i_dbl_finish = 1'b1;
                @(negedge clk);
                rif.i_dbl_finish = 1'b0;
            end
        end
    end

    // Adder responder: returns R+P after add_lat cycles, watching operands
    initial begin : add_responder
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        forever begin
            @(negedge clk);
            if (rif.o_add_start && resp_en) begin
                a1 = rif.o_add_x1;
                b1 = rif.o_add_y1;
                a2 = rif.o_add_x2;
                b2 = rif.o_add_y2;
                for (int i = 0; i < add_lat; i++) begin
                    @(negedge clk);
                    if (stab_chk && (rif.o_add_x1 !== a1 || rif.o_add_y1 !== b1 ||
                                     rif.o_add_x2 !== a2 || rif.o_add_y2 !== b2)) stab_err++;
                end
                rif.i_add_x      = a1 + a2;
                rif.i_add_y      = b1 + b2;
                rif.i_add_finish = 1'b1;
                @(negedge clk);
                rif.i_add_finish = 1'b0;
            end
        end
    end

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic any_out();
        return busy | finished | rif.o_dbl_start | rif.o_add_start |
               (|res_x) | (|res_y) | (|rif.o_dbl_x) | (|rif.o_dbl_y) |
               (|rif.o_add_x1) | (|rif.o_add_y1) | (|rif.o_add_x2) | (|rif.o_add_y2);
    endfunction

    // k*P in the multiples model; op counts and cycle cost from the bit pattern
    function automatic void ref_model(input logic [W-1:0] k, input logic [W-1:0] x,
                                      input logic [W-1:0] y, input int ld, input int la,
                                      output logic [W-1:0] ex, output logic [W-1:0] ey,
                                      output int nd, output int na, output int cyc);
        int msb;
        int pop;
        msb = -1;
        pop = 0;
        for (int i = 0; i < W; i++) begin
            if (k[i]) begin
                msb = i;
                pop++;
            end
        end
        if (pop == 0) begin
            ex = INF_V;
            ey = '0;
            nd = 0;
            na = 0;
        end else begin
            ex = k * x;
            ey = k * y;
            nd = msb;
            na = pop - 1;
        end
        cyc = 3 * W + nd * (ld + 1) + na * (la + 1) + 1;
    endfunction

    function automatic void clear_mon();
        n_dbl = 0;
        n_add = 0;
        ev_q.delete();
        ax1_q.delete();
        ay1_q.delete();
        ax2_q.delete();
        ay2_q.delete();
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request and count cycles from the acceptance edge to DONE
    task automatic run_op(input logic [W-1:0] k, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit keep_start, input int budget,
                          output int cycles, output bit timed_out);
        @(negedge clk);
        k_in  = k;
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        @(posedge clk);
        cycles    = 0;
        timed_out = 1'b1;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (keep_start) begin
                k_in = rand_w();
                x_in = rand_w();
                y_in = rand_w();
            end else begin
                start = 1'b0;
            end
            if (finished) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        k_in  = rand_w();
        x_in  = rand_w();
        y_in  = rand_w();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (any_out() !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got some output nonzero, required all zero");
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy got %b required 0", busy);
        end
        n_checks++;
        if (res_x !== '0 || res_y !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got (%h,%h) required zero", res_x, res_y);
        end
    endtask

    task automatic test_k_zero();
        logic [W-1:0] ex, ey, x, y;
        int nd, na, cyc, cycles;
        bit to;
        dbl_lat = 4;
        add_lat = 4;
        x = rand_w();
        y = rand_w();
        ref_model('0, x, y, dbl_lat, add_lat, ex, ey, nd, na, cyc);
        clear_mon();
        run_op('0, x, y, 1'b0, 1000, cycles, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL k0_timeout: got no finish, required finish");
            apply_reset();
        end
        n_checks++;
        if (cycles !== 577 || cycles !== cyc) begin
            n_fail++;
            $display("FAIL k0_latency: got %0d cycles required 577", cycles);
        end
        n_checks++;
        if (res_x !== ex || res_y !== ey) begin
            n_fail++;
            $display("FAIL k0_result: got (%h,%h) required (%h,%h)", res_x, res_y, ex, ey);
        end
        n_checks++;
        if (n_dbl !== 0 || n_add !== 0) begin
            n_fail++;
            $display("FAIL k0_no_starts: got %0d dbl %0d add, required 0 0", n_dbl, n_add);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_done: got %b required 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_one_cycle: got finished=%b busy=%b required 0 0", finished, busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (res_x !== INF_V || res_y !== '0) begin
            n_fail++;
            $display("FAIL result_hold: got (%h,%h) required (INF,0)", res_x, res_y);
        end
    endtask

    task automatic test_k_one();
        logic [W-1:0] ex, ey, x, y;
        int nd, na, cyc, cycles;
        bit to;
        dbl_lat = 4;
        add_lat = 4;
        x = W'(5);
        y = W'(7);
        ref_model(W'(1), x, y, dbl_lat, add_lat, ex, ey, nd, na, cyc);
        clear_mon();
        run_op(W'(1), x, y, 1'b0, 1000, cycles, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL k1_timeout: got no finish, required finish");
            apply_reset();
        end
        n_checks++;
        if (res_x !== W'(5) || res_y !== W'(7) || res_x !== ex) begin
            n_fail++;
            $display("FAIL k1_result: got (%h,%h) required (5,7)", res_x, res_y);
        end
        n_checks++;
        if (n_dbl !== 0 || n_add !== 0) begin
            n_fail++;
            $display("FAIL k1_no_starts: got %0d dbl %0d add, required 0 0", n_dbl, n_add);
        end
        n_checks++;
        if (cycles !== cyc) begin
            n_fail++;
            $display("FAIL k1_latency: got %0d cycles required %0d", cycles, cyc);
        end
    endtask

    task automatic test_k_six();
        logic [W-1:0] ex, ey, x, y, two;
        int nd, na, cyc, cycles;
        bit to;
        dbl_lat = 3;
        add_lat = 2;
        two = W'(2);
        x = rand_w();
        y = rand_w();
        ref_model(W'(6), x, y, dbl_lat, add_lat, ex, ey, nd, na, cyc);
        clear_mon();
        run_op(W'(6), x, y, 1'b0, 2000, cycles, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL k6_timeout: got no finish, required finish");
            apply_reset();
        end
        n_checks++;
        if (ev_q.size() !== 3 || ev_q[0] !== EV_D || ev_q[1] !== EV_A || ev_q[2] !== EV_D) begin
            n_fail++;
            $display("FAIL k6_sequence: got %0d starts, required D A D", ev_q.size());
        end
        n_checks++;
        if (ax1_q.size() !== 1 || ax1_q[0] !== two * x || ay1_q[0] !== two * y ||
            ax2_q[0] !== x || ay2_q[0] !== y) begin
            n_fail++;
            $display("FAIL k6_add_operands: got x1=%h x2=%h required 2P and P", ax1_q[0], ax2_q[0]);
        end
        n_checks++;
        if (res_x !== ex || res_y !== ey) begin
            n_fail++;
            $display("FAIL k6_result: got (%h,%h) required (%h,%h)", res_x, res_y, ex, ey);
        end
        n_checks++;
        if (cycles !== cyc) begin
            n_fail++;
            $display("FAIL k6_latency: got %0d cycles required %0d", cycles, cyc);
        end
    endtask

    task automatic test_late_finish();
        logic [W-1:0] x, y;
        int cycles;
        bit to;
        resp_en = 1'b0;
        x = rand_w();
        y = rand_w();
        rif.i_dbl_x      = rand_w();
        rif.i_dbl_y      = rand_w();
        rif.i_add_x      = rand_w();
        rif.i_add_y      = rand_w();
        rif.i_dbl_finish = 1'b1;
        rif.i_add_finish = 1'b1;
        clear_mon();
        run_op(W'(1), x, y, 1'b0, 1000, cycles, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL late_timeout: got no finish, required finish");
            apply_reset();
        end
        n_checks++;
        if (res_x !== x || res_y !== y) begin
            n_fail++;
            $display("FAIL late_finish_ignored: got (%h,%h) required (%h,%h)", res_x, res_y, x, y);
        end
        n_checks++;
        if (cycles !== 577 || n_dbl !== 0 || n_add !== 0) begin
            n_fail++;
            $display("FAIL late_finish_flow: got %0d cycles %0d/%0d starts required 577 0/0",
                     cycles, n_dbl, n_add);
        end
        rif.i_dbl_finish = 1'b0;
        rif.i_add_finish = 1'b0;
        resp_en = 1'b1;
    endtask

    // Full-width random scalars; stall > 0 forces a long responder latency
    task automatic test_random(input int iters, input int stall);
        logic [W-1:0] ex, ey, k, x, y;
        int nd, na, cyc, cycles;
        bit to;
        for (int it = 0; it < iters; it++) begin
            dbl_lat = (stall > 0) ? stall : int'($urandom_range(5, 0));
            add_lat = (stall > 0) ? stall : int'($urandom_range(5, 0));
            k = rand_w();
            x = rand_w();
            y = rand_w();
            ref_model(k, x, y, dbl_lat, add_lat, ex, ey, nd, na, cyc);
            clear_mon();
            stab_err = 0;
            run_op(k, x, y, 1'b0, cyc + 100, cycles, to);
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL rand_timeout: got no finish within %0d, required finish", cyc + 100);
                apply_reset();
            end
            n_checks++;
            if (res_x !== ex || res_y !== ey) begin
                n_fail++;
                $display("FAIL rand_result: got (%h,%h) required (%h,%h)", res_x, res_y, ex, ey);
            end
            n_checks++;
            if (n_dbl !== nd || n_add !== na) begin
                n_fail++;
                $display("FAIL rand_op_counts: got %0d/%0d required %0d/%0d", n_dbl, n_add, nd, na);
            end
            n_checks++;
            if (cycles !== cyc) begin
                n_fail++;
                $display("FAIL rand_latency: got %0d cycles required %0d", cycles, cyc);
            end
            n_checks++;
            if (stab_err !== 0) begin
                n_fail++;
                $display("FAIL operand_stability: got %0d changes required 0", stab_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, y;
        int cycles;
        bit to, seen, bad;
        dbl_lat  = 30;
        stab_chk = 1'b0;
        @(negedge clk);
        k_in  = W'(2);
        x_in  = rand_w();
        y_in  = rand_w();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rif.o_dbl_start) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_dbl_start: got no doubler start, required one");
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b required 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (any_out() !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got some output nonzero, required all zero");
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (any_out() !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL mid_late_finish: got outputs active after reset, required idle and zero");
        end
        dbl_lat  = 4;
        stab_chk = 1'b1;
        x = rand_w();
        y = rand_w();
        run_op(W'(1), x, y, 1'b0, 1000, cycles, to);
        n_checks++;
        if (to || res_x !== x || res_y !== y) begin
            n_fail++;
            $display("FAIL mid_recover: got (%h,%h) to=%b required (%h,%h)", res_x, res_y, to, x, y);
            if (to) apply_reset();
        end
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] ex1, ey1, ex2, ey2, k1, k2, x1, y1, x2, y2;
        int nd, na, cyc1, cyc2, cycles, c;
        bit to;
        dbl_lat = 2;
        add_lat = 1;
        k1 = W'($urandom());
        k2 = W'($urandom());
        x1 = rand_w();
        y1 = rand_w();
        x2 = rand_w();
        y2 = rand_w();
        ref_model(k1, x1, y1, dbl_lat, add_lat, ex1, ey1, nd, na, cyc1);
        ref_model(k2, x2, y2, dbl_lat, add_lat, ex2, ey2, nd, na, cyc2);
        run_op(k1, x1, y1, 1'b1, cyc1 + 100, cycles, to);
        n_checks++;
        if (to || res_x !== ex1 || res_y !== ey1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got (%h,%h) to=%b required (%h,%h)",
                     res_x, res_y, to, ex1, ey1);
        end
        k_in = k2;
        x_in = x2;
        y_in = y2;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_to_idle: got busy %b required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_after_done: got busy %b required 1", busy);
        end
        c = 1;
        while (!finished && c < cyc2 + 100) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (!finished || c !== cyc2 || res_x !== ex2 || res_y !== ey2) begin
            n_fail++;
            $display("FAIL second_op: got (%h,%h) in %0d cycles required (%h,%h) in %0d",
                     res_x, res_y, c, ex2, ey2, cyc2);
            if (!finished) apply_reset();
        end
    endtask

    task automatic test_pulse_rules();
        n_checks++;
        if (both_err !== 0) begin
            n_fail++;
            $display("FAIL starts_exclusive: got %0d overlaps required 0", both_err);
        end
        n_checks++;
        if (wide_err !== 0) begin
            n_fail++;
            $display("FAIL starts_single_cycle: got %0d wide pulses required 0", wide_err);
        end
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        k_in             = '0;
        x_in             = '0;
        y_in             = '0;
        rif.i_dbl_finish = 1'b0;
        rif.i_dbl_x      = '0;
        rif.i_dbl_y      = '0;
        rif.i_add_finish = 1'b0;
        rif.i_add_x      = '0;
        rif.i_add_y      = '0;
        test_reset();
        test_k_zero();
        test_k_one();
        test_k_six();
        test_late_finish();
        test_random(1, 20);
        test_random(4, 0);
        test_reset_mid();
        test_start_while_busy();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/point_mult_sequencer.md
POINT_MULT_SEQUENCER -- requirements
Module: point_mult_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 192, field element and scalar width in bits.
REQ-002 SHALL have parameter: INF, {WIDTH{1'b1}}, x-coordinate value that encodes the point at infinity.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  request to compute k*P.
REQ-006 SHALL have ports i_k, i_x, i_y  input  WIDTH each  the scalar k and the base point P = (x, y).
REQ-007 SHALL have port o_busy  output  1  high whenever the state is not IDLE.
REQ-008 SHALL have port o_finished  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports o_result_x, o_result_y  output  WIDTH each  the point k*P.
REQ-010 SHALL have doubler initiator ports:
- o_dbl_start  output  1
- o_dbl_x, o_dbl_y  output  WIDTH
- i_dbl_finish  input  1
- i_dbl_x, i_dbl_y  input  WIDTH
REQ-011 SHALL have adder initiator ports:
- o_add_start  output  1
- o_add_x1, o_add_y1, o_add_x2, o_add_y2  output  WIDTH
- i_add_finish  input  1
- i_add_x, i_add_y  input  WIDTH

Function
REQ-012 SHALL compute k*P by left-to-right double-and-add, scanning k from bit WIDTH-1 down to bit 0, using an internal accumulator R.
REQ-013 SHALL use the states IDLE, STEP, DBL_WAIT, ADD_CHK, ADD_WAIT, ADV and DONE.
REQ-014 IDLE: when i_start=1, SHALL latch i_k, i_x and i_y, set R.x=INF, set bit index idx=WIDTH-1, and go to STEP; i_start SHALL be ignored in every other state.
REQ-015 STEP: if R.x==INF, SHALL go to ADD_CHK without starting the doubler; otherwise SHALL pulse o_dbl_start and go to DBL_WAIT.
REQ-016 DBL_WAIT: on i_dbl_finish=1, SHALL set R=(i_dbl_x, i_dbl_y) and go to ADD_CHK.
REQ-017 ADD_CHK: the next state SHALL be selected as follows:
- k[idx]=0 -> go to ADV;
- k[idx]=1 and R.x==INF -> set R=P and go to ADV, with no adder start;
- otherwise -> pulse o_add_start and go to ADD_WAIT.
REQ-018 ADD_WAIT: on i_add_finish=1, SHALL set R=(i_add_x, i_add_y) and go to ADV.
REQ-019 ADV: if idx==0, SHALL go to DONE; otherwise SHALL decrement idx and go to STEP.
REQ-020 DONE: SHALL hold o_finished=1 for exactly this one cycle, present R on o_result_x/o_result_y, and return to IDLE.
REQ-021 o_dbl_start and o_add_start SHALL be registered, single-cycle pulses, and never both high in the same cycle.
REQ-022 o_dbl_x/o_dbl_y and o_add_x1/o_add_y1 SHALL be driven from R, and o_add_x2/o_add_y2 from latched P; all SHALL stay stable from the start pulse until the matching finish is sampled.
REQ-023 i_dbl_finish SHALL be ignored outside DBL_WAIT, and i_add_finish SHALL be ignored outside ADD_WAIT.
REQ-024 The wait states SHALL have no timeout; the sequencer waits indefinitely for the responder.
REQ-025 Degenerate additions (R==P, R==-P) SHALL be the adder's responsibility; the sequencer forwards operands unchanged.
REQ-026 o_result_x/o_result_y SHALL hold their value from DONE until the next DONE or reset.
REQ-027 Cycle cost per bit SHALL be:
- 3 cycles (STEP, ADD_CHK, ADV) while R is INF;
- plus the doubler latency + 1 when doubling;
- plus the adder latency + 1 when adding.
REQ-028 k=0 SHALL yield o_result_x=INF, and the result y SHALL be the y value R holds while at infinity, which is 0.

Reset
REQ-029 When i_rst=1 at a clock edge, the block SHALL go to IDLE regardless of state, and an in-flight responder operation SHALL be abandoned; its finish is later ignored per REQ-023.
REQ-030 While i_rst=1, SHALL force all outputs to 0: o_busy, o_finished, both start pulses, all result and operand ports.
REQ-031 While i_rst=1, SHALL clear R, P, k and idx to 0.
REQ-032 i_start sampled in the same cycle as i_rst=1 SHALL be ignored.

Verification
REQ-033 k=0, responders idle -> no start pulses at all; o_finished exactly 577 cycles after the acceptance edge (192 bits × 3 cycles + DONE); result x=INF.
REQ-034 k=1, P=(5,7), responders finishing after 4 cycles -> zero doubler starts, zero adder starts; result=(5,7).
REQ-035 k=6 (binary 110), model responders doing integer doubling/adding -> start sequence SHALL be:
- dbl, add, dbl;
- o_add operands (2P, P);
- result equals the model's 6P.
REQ-036 Late finish: finish asserted while in ADD_CHK -> ignored, state unchanged; operands held stable across a 20-cycle responder stall.
REQ-037 Reset mid-operation: i_rst in DBL_WAIT, then a late i_dbl_finish -> block stays IDLE with all outputs 0; next i_start with k=1 completes normally.
REQ-038 i_start re-asserted while busy -> ignored and the result unaffected; i_start in the cycle after DONE -> accepted.
